// File: rtl/mips32_dump_pkg.sv
// mips32_dump_pkg: shared state encoding and source tags for the state dumper
package mips32_dump_pkg;
  typedef enum logic [1:0] {S_IDLE, S_REG, S_MEM, S_DRAIN} state_t;
  localparam logic SRC_REG = 1'b0;
  localparam logic SRC_MEM = 1'b1;
endpackage

// File: rtl/mips32_dump_slot.sv
// mips32_dump_slot: one-entry output register with valid/ready handshake
module mips32_dump_slot #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clr,
  input  logic [31:0]   d_data,
  input  logic [AW-1:0] d_addr,
  input  logic          d_src,
  input  logic          ready,
  output logic          free,
  output logic          valid,
  output logic [31:0]   data,
  output logic [AW-1:0] addr,
  output logic          src
);
  assign free = !valid || ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      addr  <= '0;
      src   <= 1'b0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d_data;
      addr  <= d_addr;
      src   <= d_src;
    end
  end
endmodule

// File: rtl/mips32_state_dumper.sv
// mips32_state_dumper: freezes the core and streams register file then data memory out
module mips32_state_dumper
  import mips32_dump_pkg::*;
#(
  parameter int REG_COUNT  = 32,
  parameter int DATA_DEPTH = 256,
  parameter int AW         = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          cpu_hold,
  output logic [4:0]    reg_rd_addr,
  input  logic [31:0]   reg_rd_data,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [31:0]   mem_rd_data,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic          dump_src,
  output logic [AW-1:0] dump_addr,
  output logic [31:0]   dump_data
);
  state_t        state, state_n;
  logic [AW-1:0] idx, idx_n;
  logic          done_n, free, load, clr, in_mem, last_reg, last_mem;
  assign in_mem   = state == S_MEM;
  assign load     = free && (state == S_REG || in_mem);
  assign clr      = state == S_DRAIN && dump_valid && dump_ready;
  assign last_reg = idx == AW'(REG_COUNT - 1);
  assign last_mem = idx == AW'(DATA_DEPTH - 1);
  assign busy        = state != S_IDLE;
  assign cpu_hold    = busy;
  assign reg_rd_addr = idx[4:0];
  assign mem_rd_addr = idx;
  always_comb begin
    state_n = state;
    idx_n   = idx;
    done_n  = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        state_n = S_REG;
        idx_n   = '0;
      end
      S_REG: if (load) begin
        state_n = last_reg ? S_MEM : S_REG;
        idx_n   = last_reg ? '0 : idx + 1'b1;
      end
      S_MEM: if (load) begin
        state_n = last_mem ? S_DRAIN : S_MEM;
        idx_n   = last_mem ? idx : idx + 1'b1;
      end
      S_DRAIN: if (clr) begin
        state_n = S_IDLE;
        idx_n   = '0;
        done_n  = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      done  <= done_n;
    end
  end
  mips32_dump_slot #(.AW(AW)) u_slot (
    .clk    (clock),
    .rst    (reset),
    .load   (load),
    .clr    (clr),
    .d_data (in_mem ? mem_rd_data : reg_rd_data),
    .d_addr (idx),
    .d_src  (in_mem ? SRC_MEM : SRC_REG),
    .ready  (dump_ready),
    .free   (free),
    .valid  (dump_valid),
    .data   (dump_data),
    .addr   (dump_addr),
    .src    (dump_src)
  );
endmodule

// File: tb/tb_mips32_state_dumper.sv
// tb_mips32_state_dumper: directed checks of dump order, handshake, stalls, restart and reset
module tb_mips32_state_dumper;
  logic        clk = 1'b0;
  logic        reset, start, dump_ready;
  logic        busy, done, cpu_hold, dump_valid, dump_src;
  logic [4:0]  reg_rd_addr;
  logic [7:0]  mem_rd_addr, dump_addr;
  logic [31:0] reg_rd_data, mem_rd_data, dump_data;
  logic [31:0] regs [32];
  logic [31:0] mem  [256];
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  assign reg_rd_data = regs[reg_rd_addr];
  assign mem_rd_data = mem[mem_rd_addr];
  mips32_state_dumper dut (
    .clock       (clk),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .cpu_hold    (cpu_hold),
    .reg_rd_addr (reg_rd_addr),
    .reg_rd_data (reg_rd_data),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .dump_valid  (dump_valid),
    .dump_ready  (dump_ready),
    .dump_src    (dump_src),
    .dump_addr   (dump_addr),
    .dump_data   (dump_data)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("hold_after_start", {31'd0, cpu_hold}, 32'd1);
    check("valid_lat", {31'd0, dump_valid}, 32'd0);
  endtask
  // mode 0: ready always high, 1: random ready, 2: 20-cycle stall on reg 31
  task automatic run_dump(input int mode, input bit pulses, input int rst_k);
    int k = 0;
    int cyc = 0;
    int stall = 0;
    int gaps = 0;
    bit aborted = 0;
    logic r, pv = 0, pr = 0, ps = 0;
    logic [7:0] pa = 0;
    logic [31:0] pd = 0;
    while (k < 288 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      start = pulses && (cyc == 10 || cyc == 50);
      if (mode == 0 && cyc == 1) check("first_valid", {31'd0, dump_valid}, 32'd1);
      if (mode == 0 && !dump_valid) gaps++;
      if (pv && !pr) begin
        check("stall_valid", {31'd0, dump_valid}, 32'd1);
        check("stall_data", dump_data, pd);
        check("stall_addr", {24'd0, dump_addr}, {24'd0, pa});
        check("stall_src", {31'd0, dump_src}, {31'd0, ps});
      end
      r = 1'b1;
      if (mode == 1) r = 1'($urandom_range(1));
      if (mode == 2 && dump_valid && !dump_src && dump_addr == 8'd31 && stall < 20) begin
        r = 1'b0;
        stall++;
      end
      dump_ready = r;
      if (dump_valid && r) begin
        check("src", {31'd0, dump_src}, k >= 32 ? 32'd1 : 32'd0);
        check("addr", {24'd0, dump_addr}, k < 32 ? k : k - 32);
        check("data", dump_data, k < 32 ? k * 3 : 32'hA000_0000 + (k - 32));
        k++;
      end
      pv = dump_valid; pr = r; pd = dump_data; pa = dump_addr; ps = dump_src;
      if (rst_k > 0 && k == rst_k) begin
        reset = 1'b1;
        aborted = 1;
        break;
      end
    end
    start = 1'b0;
    dump_ready = 1'b1;
    if (aborted) begin
      @(negedge clk);
      check("rst_valid", {31'd0, dump_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_hold", {31'd0, cpu_hold}, 32'd0);
      check("rst_addr", {24'd0, dump_addr}, 32'd0);
      check("rst_data", dump_data, 32'd0);
      reset = 1'b0;
    end else begin
      check("word_count", k, 288);
      if (mode == 0) check("gaps", gaps, 0);
      if (mode == 2) check("stall_len", stall, 20);
      @(negedge clk);
      check("done_pulse", {31'd0, done}, 32'd1);
      check("busy_end", {31'd0, busy}, 32'd0);
      check("valid_end", {31'd0, dump_valid}, 32'd0);
      @(negedge clk);
      check("done_once", {31'd0, done}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
    end
  endtask
  initial begin
    for (int i = 0; i < 32; i++) regs[i] = i * 3;
    for (int j = 0; j < 256; j++) mem[j] = 32'hA000_0000 + j;
    reset = 1'b1; start = 1'b0; dump_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_valid", {31'd0, dump_valid}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_regaddr", {27'd0, reg_rd_addr}, 32'd0);
    check("reset_memaddr", {24'd0, mem_rd_addr}, 32'd0);
    check("reset_data", dump_data, 32'd0);
    repeat (2) @(negedge clk);
    pulse_start();
    run_dump(0, 0, 0);
    pulse_start();
    run_dump(1, 0, 0);
    pulse_start();
    run_dump(2, 0, 0);
    pulse_start();
    run_dump(0, 1, 0);
    pulse_start();
    run_dump(0, 0, 100);
    repeat (2) @(negedge clk);
    pulse_start();
    run_dump(0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
